// File: rtl/downsample_2d.sv
// 2-D pixel decimator: keeps pixels on the SCALE_X/SCALE_Y grid behind a 1-cycle output register.
// Optional DOWNSAMPLE_2D_EOL_EN adds out_eol/out_eof markers aligned with out_data.
module downsample_2d #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned SCALE_X = 2,
  parameter int unsigned SCALE_Y = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef DOWNSAMPLE_2D_EOL_EN
  ,
  output logic              out_eol,
  output logic              out_eof
`endif
);

  localparam int unsigned XW  = (IMG_W   > 1) ? $clog2(IMG_W)   : 1;
  localparam int unsigned YW  = (IMG_H   > 1) ? $clog2(IMG_H)   : 1;
  localparam int unsigned PXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int unsigned PYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  logic [XW-1:0]     x_q, x_d, x_e;
  logic [YW-1:0]     y_q, y_d, y_e;
  logic [PXW-1:0]    px_q, px_d, px_e;
  logic [PYW-1:0]    py_q, py_d, py_e;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sof_c, keep_c, accept_c;

`ifdef DOWNSAMPLE_2D_EOL_EN
  // Column/row of the last grid pixel in a line/frame.
  localparam int unsigned LAST_KX = ((IMG_W - 1) / SCALE_X) * SCALE_X;
  localparam int unsigned LAST_KY = ((IMG_H - 1) / SCALE_Y) * SCALE_Y;
  logic out_eol_q, out_eol_d, out_eof_q, out_eof_d;
`endif

  always_comb begin
    sof_c       = in_valid & in_sof;
    x_e         = sof_c ? '0 : x_q;
    y_e         = sof_c ? '0 : y_q;
    px_e        = sof_c ? '0 : px_q;
    py_e        = sof_c ? '0 : py_q;
    keep_c      = (px_e == '0) && (py_e == '0);
    in_ready    = !keep_c || !out_valid_q || out_ready;
    accept_c    = in_valid && in_ready;
    x_d         = x_q;
    y_d         = y_q;
    px_d        = px_q;
    py_d        = py_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef DOWNSAMPLE_2D_EOL_EN
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
`endif

    // Raster counters; phases restart at every line so columns stay grid-aligned.
    if (accept_c) begin
      if (x_e == XW'(IMG_W - 1)) begin
        x_d  = '0;
        px_d = '0;
        if (y_e == YW'(IMG_H - 1)) begin
          y_d  = '0;
          py_d = '0;
        end else begin
          y_d  = y_e + YW'(1);
          py_d = (py_e == PYW'(SCALE_Y - 1)) ? '0 : py_e + PYW'(1);
        end
      end else begin
        x_d  = x_e + XW'(1);
        px_d = (px_e == PXW'(SCALE_X - 1)) ? '0 : px_e + PXW'(1);
        y_d  = y_e;
        py_d = py_e;
      end
    end

    if (accept_c && keep_c) begin
      out_data_d  = in_data;
      out_valid_d = 1'b1;
`ifdef DOWNSAMPLE_2D_EOL_EN
      out_eol_d   = (x_e == XW'(LAST_KX));
      out_eof_d   = (x_e == XW'(LAST_KX)) && (y_e == YW'(LAST_KY));
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef DOWNSAMPLE_2D_EOL_EN
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
`endif
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      px_q        <= px_d;
      py_q        <= py_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef DOWNSAMPLE_2D_EOL_EN
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef DOWNSAMPLE_2D_EOL_EN
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
`endif

endmodule

// File: tb/tb_downsample_2d.sv
// Directed bench for downsample_2d on a 6x4 image (scale 2 and scale 1 instances).
// Pixel value equals its raster index, so kept pixels of a scale-2 frame are 0,2,4,12,14,16.
module tb_downsample_2d;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, in_ready1;
  logic [7:0] out_data, out_data1;
  logic       out_valid, out_valid1;
`ifdef DOWNSAMPLE_2D_EOL_EN
  logic       out_eol, out_eof, out_eol1, out_eof1;
`endif

  int n_total = 0;
  int n_bad   = 0;
  bit use1    = 1'b0;
  int got[$];
  int got1[$];
  int flags[$];
  int exp_q[$];

  always #5 clk = ~clk;

  downsample_2d #(.DATA_W(8), .IMG_W(6), .IMG_H(4), .SCALE_X(2), .SCALE_Y(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DOWNSAMPLE_2D_EOL_EN
    , .out_eol(out_eol), .out_eof(out_eof)
`endif
  );

  downsample_2d #(.DATA_W(8), .IMG_W(6), .IMG_H(4), .SCALE_X(1), .SCALE_Y(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready)
`ifdef DOWNSAMPLE_2D_EOL_EN
    , .out_eol(out_eol1), .out_eof(out_eof1)
`endif
  );

  // Output transfers, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back(int'(out_data));
`ifdef DOWNSAMPLE_2D_EOL_EN
      flags.push_back(int'(out_eol) + 2 * int'(out_eof));
`endif
    end
    if (!rst && out_valid1 && out_ready) got1.push_back(int'(out_data1));
  end

  task automatic check_eq(input string tag, input int act, input int req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, act, req);
    end
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_len"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      check_eq($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
  endtask

  task automatic push_frame_exp();
    exp_q.push_back(0);  exp_q.push_back(2);  exp_q.push_back(4);
    exp_q.push_back(12); exp_q.push_back(14); exp_q.push_back(16);
  endtask

  // Present one beat and hold it until accepted; returns cycles taken.
  task automatic send(input int d, input bit sof, output int cyc);
    bit r;
    in_data  = 8'(d);
    in_sof   = sof;
    in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      r = use1 ? in_ready1 : in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!r && cyc < 50);
    if (!r) check_eq("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit sof, input int gap, output int tot);
    int c;
    tot = 0;
    for (int i = lo; i <= hi; i++) begin
      send(i, sof && (i == lo), c);
      tot += c;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full-rate frame, 1-cycle latency, never back-pressured
    got.delete(); flags.delete(); exp_q.delete();
    send(0, 1'b1, c);
    check_eq("t1_lat_valid", int'(out_valid), 1);
    check_eq("t1_lat_data", int'(out_data), 0);
    send_range(1, 23, 1'b0, 0, t);
    check_eq("t1_cycles", t + c, 24);
    drain();
    push_frame_exp();
    check_seq("t1");
`ifdef DOWNSAMPLE_2D_EOL_EN
    foreach (flags[i])
      check_eq($sformatf("t1_flags[%0d]", i), flags[i], (i == 2) ? 1 : (i == 5) ? 3 : 0);
`endif

    // 2: downstream stall from the second kept pixel
    got.delete(); exp_q.delete();
    send_range(0, 2, 1'b1, 0, t);
    out_ready = 1'b0;
    send(3, 1'b0, c);
    check_eq("t2_drop_cycles", c, 1);
    in_data = 8'd4; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("t2_in_ready", int'(in_ready), 0);
      check_eq("t2_hold_valid", int'(out_valid), 1);
      check_eq("t2_hold_data", int'(out_data), 2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4, 1'b0, c);
    check_eq("t2_release_cycles", c, 1);
    send_range(5, 23, 1'b0, 0, t);
    drain();
    push_frame_exp();
    check_seq("t2");

    // 3: input gaps
    got.delete(); exp_q.delete();
    send_range(0, 23, 1'b1, 2, t);
    drain();
    push_frame_exp();
    check_seq("t3");

    // 4: frame truncated by in_sof at beat 9, then two whole frames
    got.delete(); exp_q.delete();
    send_range(0, 8, 1'b1, 0, t);
    send_range(0, 23, 1'b1, 0, t);
    send_range(0, 23, 1'b0, 0, t);
    drain();
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(4);
    push_frame_exp();
    push_frame_exp();
    check_seq("t4");

    // 5: asynchronous reset while an output beat is pending
    send_range(0, 2, 1'b1, 0, t);
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", int'(out_valid), 0);
    check_eq("t5_rst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    got.delete(); exp_q.delete();
    send_range(55, 57, 1'b0, 0, t);
    drain();
    exp_q.push_back(55); exp_q.push_back(57);
    check_seq("t5");

    // 6: scale 1 is a full-rate registered pass-through
    use1 = 1'b1;
    drain();
    got1.delete(); exp_q.delete();
    send_range(0, 23, 1'b1, 0, t);
    check_eq("t6_cycles", t, 24);
    drain();
    got = got1;
    for (int i = 0; i < 24; i++) exp_q.push_back(i);
    check_seq("t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
